// File: rtl/cla_pg_pipe_if.sv
// Operand/result stream bundle for cla_pg_pipe.
// Optional macro CLA_OVF_EN adds the signed-overflow flag ovf_o.
interface cla_pg_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p_o;
    logic [WIDTH-1:0] c_o;
    logic             cout_o;
`ifdef CLA_OVF_EN
    logic             ovf_o;

    // Producer of operands / consumer of propagate-carry results
    modport master (
        output in_valid, a_i, b_i, sub_i, out_ready,
        input  in_ready, out_valid, p_o, c_o, cout_o, ovf_o
    );

    // The pipeline itself
    modport slave (
        input  in_valid, a_i, b_i, sub_i, out_ready,
        output in_ready, out_valid, p_o, c_o, cout_o, ovf_o
    );
`else
    // Producer of operands / consumer of propagate-carry results
    modport master (
        output in_valid, a_i, b_i, sub_i, out_ready,
        input  in_ready, out_valid, p_o, c_o, cout_o
    );

    // The pipeline itself
    modport slave (
        input  in_valid, a_i, b_i, sub_i, out_ready,
        output in_ready, out_valid, p_o, c_o, cout_o
    );
`endif
endinterface

// File: rtl/cla_pg_pipe.sv
// Two-stage carry-lookahead propagate/carry pipeline.
// S1 registers per-bit propagate/generate and carry-in; S2 resolves carries
// with 4-bit lookahead groups and registers p_o, c_o and cout_o. The sum
// itself (p_o ^ c_o) is formed downstream.
// Optional macro CLA_OVF_EN adds a registered signed-overflow flag ovf_o.
// WIDTH must be a multiple of 4 (8, 16 or 32).
module cla_pg_pipe #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    cla_pg_pipe_if.slave bus
);
    localparam int NGRP = WIDTH / 4;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_cin;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_p;
    logic [WIDTH-1:0] s2_c;
    logic             s2_cout;
`ifdef CLA_OVF_EN
    logic             s2_ovf;
`endif

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] c_next;
    logic             cout_next;

    // Subtraction is a + ~b + 1, so the operand is inverted here and cin set in S1
    assign b_eff = bus.sub_i ? ~bus.b_i : bus.b_i;

    // A stage may load when it is empty or its contents move on this cycle
    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = s2_valid;
    assign bus.p_o       = s2_p;
    assign bus.c_o       = s2_c;
    assign bus.cout_o    = s2_cout;
`ifdef CLA_OVF_EN
    assign bus.ovf_o     = s2_ovf;
`endif

    // Carries into each bit of a 4-bit group plus the group carry-out, all in
    // flattened sum-of-products form so no carry ripples inside the group
    function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & ci);
        return c;
    endfunction

    // Chain the group lookahead units to get every bit's carry-in and the final carry-out
    always_comb begin
        logic [NGRP:0] grp_c;
        logic [4:0]    grp;
        c_next    = '0;
        cout_next = 1'b0;
        grp_c     = '0;
        grp       = '0;
        grp_c[0]  = s1_cin;
        for (int k = 0; k < NGRP; k++) begin
            grp                = cla4(s1_p[4*k +: 4], s1_g[4*k +: 4], grp_c[k]);
            c_next[4*k +: 4]   = grp[3:0];
            grp_c[k+1]         = grp[4];
        end
        cout_next = grp_c[NGRP];
    end

    // S1: capture propagate/generate and carry-in only when a beat is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_p   <= bus.a_i ^ b_eff;
                s1_g   <= bus.a_i & b_eff;
                s1_cin <= bus.sub_i;
            end
        end
    end

    // S2: register resolved carries; everything holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_c     <= '0;
            s2_cout  <= 1'b0;
`ifdef CLA_OVF_EN
            s2_ovf   <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p    <= s1_p;
                s2_c    <= c_next;
                s2_cout <= cout_next;
`ifdef CLA_OVF_EN
                s2_ovf  <= c_next[WIDTH-1] ^ cout_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_pg_pipe.sv
// Self-checking bench for cla_pg_pipe (WIDTH=32) using a plain-arithmetic
// reference model. Honours CLA_OVF_EN the same way the design does.
module tb_cla_pg_pipe;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    cla_pg_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_pg_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] p;
        logic [31:0] c;
        logic        cout;
        logic        ovf;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Reference: full 33-bit sum; carries recovered as sum ^ propagate
    function automatic beat_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        beat_t       r;
        logic [32:0] full;
        logic [31:0] bb;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
        r.p    = a ^ bb;
        r.c    = full[31:0] ^ r.p;
        r.cout = full[32];
`ifdef CLA_OVF_EN
        r.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
`else
        r.ovf  = 1'b0;
`endif
        return r;
    endfunction

    // One cycle: drive at negedge, sample 1 time unit later
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic sb, input logic ordy,
                        output logic acc, output logic ov, output beat_t got);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a_i       = a;
        bus.b_i       = b;
        bus.sub_i     = sb;
        bus.out_ready = ordy;
        #1;
        acc      = iv & bus.in_ready;
        ov       = bus.out_valid;
        got.p    = bus.p_o;
        got.c    = bus.c_o;
        got.cout = bus.cout_o;
`ifdef CLA_OVF_EN
        got.ovf  = bus.ovf_o;
`else
        got.ovf  = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic  acc, ov;
        beat_t got, exp;
        int    n;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_flags got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
        end
        n_cmp++;
        if ({bus.p_o, bus.c_o, bus.cout_o} !== 65'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data got %h exp 0", {bus.p_o, bus.c_o, bus.cout_o});
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready got %b exp 1", bus.in_ready);
        end
        // Release and offer a beat for the very first edge after release
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a_i       = 32'd3;
        bus.b_i       = 32'd4;
        bus.sub_i     = 1'b0;
        bus.out_ready = 1'b1;
        exp = model(32'd3, 32'd4, 1'b0);
        n = 0;
        ov = 1'b0;
        got = '0;
        while (!ov && n < 6) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov, got);
            n++;
        end
        n_cmp++;
        if (n !== 2 || got !== exp) begin
            n_fail++;
            $display("[TB] FAIL first_accept got lat=%0d %h exp lat=2 %h", n, got, exp);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[3]   = '{32'h0000_0001, 32'd5, 32'h7FFF_FFFF};
        logic [31:0] vb[3]   = '{32'hFFFF_FFFF, 32'd7, 32'd1};
        logic        vs[3]   = '{1'b0, 1'b1, 1'b0};
        logic [31:0] vsum[3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h8000_0000};
        logic        vco[3]  = '{1'b1, 1'b0, 1'b0};
        logic        vov[3]  = '{1'b0, 1'b0, 1'b1};
        logic        acc, ov;
        beat_t       got;
        int          n;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, va[i], vb[i], vs[i], 1'b1, acc, ov, got);
            n_cmp++;
            if (acc !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL dir_accept[%0d] got %b exp 1", i, acc);
            end
            n = 0;
            ov = 1'b0;
            while (!ov && n < 6) begin
                step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov, got);
                n++;
            end
            n_cmp++;
            if (n !== 2) begin
                n_fail++;
                $display("[TB] FAIL dir_latency[%0d] got %0d exp 2", i, n);
            end
            n_cmp++;
            if ((got.p ^ got.c) !== vsum[i] || got.cout !== vco[i]) begin
                n_fail++;
                $display("[TB] FAIL dir_sum[%0d] got %h/%b exp %h/%b", i, got.p ^ got.c, got.cout, vsum[i], vco[i]);
            end
`ifdef CLA_OVF_EN
            n_cmp++;
            if (got.ovf !== vov[i]) begin
                n_fail++;
                $display("[TB] FAIL dir_ovf[%0d] got %b exp %b", i, got.ovf, vov[i]);
            end
`else
            if (vov[i] === 1'bx) $display("[TB] unreachable");
`endif
            if (i == 0) begin
                n_cmp++;
                if (got.p !== 32'hFFFF_FFFE || got.c !== 32'hFFFF_FFFE) begin
                    n_fail++;
                    $display("[TB] FAIL dir_pc got p=%h c=%h exp p=fffffffe c=fffffffe", got.p, got.c);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        acc, ov;
        beat_t       got, exp;
        logic [31:0] a, b;
        logic        sb;
        for (int i = 0; i < 14; i++) begin
            a  = $urandom;
            b  = $urandom;
            sb = 1'($urandom_range(0, 1));
            step(i < 10, a, b, sb, 1'b1, acc, ov, got);
            n_cmp++;
            if (acc !== (i < 10) || ov !== (i >= 2 && i < 12)) begin
                n_fail++;
                $display("[TB] FAIL b2b_flags[%0d] got acc=%b ov=%b exp acc=%b ov=%b", i, acc, ov, i < 10, i >= 2 && i < 12);
            end
            if (ov) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_data[%0d] got %h exp %h", i, got, exp);
                end
            end
            if (acc) exp_q.push_back(model(a, b, sb));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] da[4], db[4];
        logic        ds[4];
        logic        acc, ov;
        beat_t       got, snap, exp;
        int          nxt, cnt, k;
        for (int i = 0; i < 4; i++) begin
            da[i] = $urandom;
            db[i] = $urandom;
            ds[i] = 1'($urandom_range(0, 1));
        end
        nxt  = 0;
        snap = '0;
        for (int i = 0; i < 5; i++) begin
            k = (nxt < 4) ? nxt : 3;
            step(1'b1, da[k], db[k], ds[k], 1'b0, acc, ov, got);
            n_cmp++;
            if (acc !== (i < 2)) begin
                n_fail++;
                $display("[TB] FAIL bp_accept[%0d] got %b exp %b", i, acc, i < 2);
            end
            if (i == 2) begin
                snap = got;
                exp  = (exp_q.size() > 0) ? exp_q[0] : '0;
                n_cmp++;
                if (ov !== 1'b1 || got !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL bp_head got ov=%b %h exp ov=1 %h", ov, got, exp);
                end
            end else if (i > 2) begin
                n_cmp++;
                if (ov !== 1'b1 || got !== snap) begin
                    n_fail++;
                    $display("[TB] FAIL bp_hold[%0d] got ov=%b %h exp ov=1 %h", i, ov, got, snap);
                end
            end
            if (acc) begin
                exp_q.push_back(model(da[k], db[k], ds[k]));
                nxt++;
            end
        end
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            k = (nxt < 4) ? nxt : 3;
            step(nxt < 4, da[k], db[k], ds[k], 1'b1, acc, ov, got);
            if (ov) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                cnt++;
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL bp_drain[%0d] got %h exp %h", cnt, got, exp);
                end
            end
            if (acc) begin
                exp_q.push_back(model(da[k], db[k], ds[k]));
                nxt++;
            end
        end
        n_cmp++;
        if (cnt !== 4 || nxt !== 4) begin
            n_fail++;
            $display("[TB] FAIL bp_count got out=%0d in=%0d exp out=4 in=4", cnt, nxt);
        end
    endtask

    task automatic test_random();
        logic        acc, ov, iv, ordy, sb;
        logic        prev_stall;
        logic [31:0] a, b;
        beat_t       got, prev, exp;
        prev_stall = 1'b0;
        prev       = '0;
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a    = $urandom;
            b    = (i % 17 == 0) ? a : $urandom;
            sb   = 1'($urandom_range(0, 1));
            step(iv, a, b, sb, ordy, acc, ov, got);
            if (prev_stall) begin
                n_cmp++;
                if (ov !== 1'b1 || got !== prev) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_hold[%0d] got ov=%b %h exp ov=1 %h", i, ov, got, prev);
                end
            end
            if (ov && ordy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_extra[%0d] got %h exp no beat", i, got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL rnd_data[%0d] got %h exp %h", i, got, exp);
                    end
                end
            end
            if (acc) exp_q.push_back(model(a, b, sb));
            prev_stall = ov & ~ordy;
            prev       = got;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov, got);
            if (ov) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_drain[%0d] got %h exp %h", i, got, exp);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL rnd_left got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic  acc, ov;
        beat_t got;
        step(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, acc, ov, got);
        step(1'b1, 32'h8765_4321, 32'h1111_1111, 1'b1, 1'b0, acc, ov, got);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc, ov, got);
        n_cmp++;
        if (ov !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_inflight got ov=%b exp 1", ov);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
            || {bus.p_o, bus.c_o, bus.cout_o} !== 65'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset got ov=%b rdy=%b %h exp ov=0 rdy=1 0", bus.out_valid, bus.in_ready, {bus.p_o, bus.c_o, bus.cout_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov, got);
            n_cmp++;
            if (ov !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL mid_stale[%0d] got ov=%b exp 0", i, ov);
            end
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] timeout");
    end

    // Test sequence
    initial begin
        bus.in_valid  = 1'b0;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.sub_i     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
